fft_agu_core: RTL and testbench
===============================

# fft_agu_core

Address-generation and sequencing unit for the in-place radix-2 FFT engine. On `start` it walks all N_2 butterfly levels, N/2 butterflies per level at one per cycle, and drives the two ping-pong RAMs, the read-mux select and the twiddle-ROM address. It sits between the control FSM and the butterfly unit (`fft_butterfly`), the twiddle ROM and the two `twoport_RAM` banks, and raises `done` when the transform is complete.

## Interface
- `width`, 16: datapath half-width; affects no logic here and is kept for instantiation symmetry with the datapath.
- `N_2`, 5: log2 of the FFT length; N = 2^N_2 points.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: request a transform; sampled on `clk`.
- `done` out 1: transform complete.
- `rdsel` out 1: butterfly input mux; 0 selects RAM0 read data, 1 selects RAM1.
- `we0` out 1: RAM0 write enable, both ports.
- `adr0a`, `adr0b` out N_2: RAM0 port A and port B addresses.
- `we1` out 1: RAM1 write enable, both ports.
- `adr1a`, `adr1b` out N_2: RAM1 port A and port B addresses.
- `twiddleadr` out N_2-1: twiddle ROM address.

## Operation
- States:
  - IDLE: entered on reset.
  - RUN: entered from IDLE or DONE when `start`=1. `start` is ignored in RUN.
  - DONE: entered after the last level's write. Leaves to RUN on `start`=1.
- Counters: level `l` runs 0..N_2-1; butterfly `j` runs 0..N/2-1.
- Level length: each level takes N/2 read cycles plus one drain cycle, so N/2+1 cycles per level.
- Read addresses for butterfly (l, j), with rotl meaning an N_2-bit rotate-left:
  - A = rotl(2j, l).
  - B = rotl(2j+1, l).
- Twiddle address: `twiddleadr` = j AND mask, where mask keeps the top l bits of the N_2-1-bit value. Level 0 gives 0; level N_2-1 gives j.
- Ping-pong:
  - Even levels read RAM0 and write RAM1; odd levels read RAM1 and write RAM0.
  - `rdsel` = l[0].
  - The reading RAM's address ports carry the current read addresses, with its `we` low.
  - The writing RAM's ports carry the read addresses delayed one cycle, with its `we` high for exactly the cycles that follow a read cycle.
- Drain cycle: the reading RAM's addresses are 0 and only the final write of the level occurs. This keeps the next level from reading a bank while it is still being written.
- Outside RUN: `we0`=`we1`=0, all addresses 0, `twiddleadr`=0, and `rdsel` holds its last value.
- Reset values: `done`=0, `rdsel`=0, `we0`=`we1`=0, all addresses and `twiddleadr` 0.
- Reset mid-run: the block returns to IDLE immediately, with no further writes.

## Timing
- Cycle numbering: the start edge is E0, and cycle k is the period after edge k.
- Read timing: butterfly (l, j) read addresses are valid in cycle l·(N/2+1)+j+1. RAM reads are synchronous.
- Write timing: the matching write (`we` high, delayed addresses) occurs in the next cycle. The butterfly is combinational.
- Completion: `done` rises at edge N_2·(N/2+1)+1 after E0, which is 86 for the defaults.
- `done` release: `done` stays high until the edge that accepts the next `start`, where it clears as RUN begins.
- Result location: the final result is in RAM1 when N_2 is odd and in RAM0 when N_2 is even.

## Configuration
- `FFT_AGU_DONE_PULSE_EN` defined: `done` is a single-cycle pulse at completion. The FSM then returns to IDLE.
- Macro undefined (default): `done` is held as described under Timing.

## Test plan
- Reset behaviour: hold `reset`=0 with `start`=1 -> all outputs 0; the FSM stays IDLE.
- Level 0 addressing: pulse `start` -> cycle 1 shows `adr0a`=0, `adr0b`=1, `twiddleadr`=0, `we0`=0, `rdsel`=0; cycle 2 shows `we1`=1, `adr1a`=0, `adr1b`=1.
- Mid-transform addressing:
  - Level 1, j=5: `adr1a`=20, `adr1b`=22, `twiddleadr`=0, `rdsel`=1.
  - Level 4, j=5: `adr0a`=5, `adr0b`=21, `twiddleadr`=5.
- Level boundary: cycle 17 -> `we0`=`we1`=0 on the read side; `we1`=1 with `adr1a`=30 and `adr1b`=31; level 1 first read occurs in cycle 18 with `adr1a`=0 and `adr1b`=2.
- Completion: `done` rises exactly 86 edges after start; a second `start` while in RUN changes nothing; a `start` in DONE clears `done` and restarts the sequence.
- Reset mid-run: assert `reset` at cycle 40 -> outputs go to 0 asynchronously, and the next `start` restarts from level 0.

Source files
------------

// File: rtl/fft_agu_core_if.sv
// Bus bundle between fft_agu_core and the FFT datapath: start/done handshake,
// ping-pong RAM controls and the twiddle ROM address.
interface fft_agu_core_if #(
  parameter int N_2 = 5
);
  logic           start;
  logic           done;
  logic           rdsel;
  logic           we0;
  logic [N_2-1:0] adr0a;
  logic [N_2-1:0] adr0b;
  logic           we1;
  logic [N_2-1:0] adr1a;
  logic [N_2-1:0] adr1b;
  logic [N_2-2:0] twiddleadr;

  modport master (
    input  start,
    output done, rdsel, we0, adr0a, adr0b, we1, adr1a, adr1b, twiddleadr
  );

  modport slave (
    output start,
    input  done, rdsel, we0, adr0a, adr0b, we1, adr1a, adr1b, twiddleadr
  );
endinterface

// File: rtl/fft_agu_core.sv
// Address generator / sequencer for the in-place radix-2 FFT (ping-pong RAMs).
// Build option FFT_AGU_DONE_PULSE_EN: done is a one-cycle pulse and the FSM returns to IDLE.
module fft_agu_core #(
  parameter int width = 16,
  parameter int N_2   = 5
) (
  input  logic           clk,
  input  logic           reset,
  fft_agu_core_if.master bus
);

  localparam int HALF = 2 ** (N_2 - 1);
  localparam int LW   = (N_2 > 1) ? $clog2(N_2) : 1;
  // width only mirrors the datapath parameter list; a degenerate width never starts
  localparam bit WidthOk = (width > 0);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e         state_q, state_d;
  logic [LW-1:0]  lvl_q, lvl_d;
  logic [N_2-1:0] pos_q, pos_d;
  logic           tail_q, tail_d;
  logic [N_2-1:0] rda_q, rda_d, rdb_q, rdb_d;

  logic           done_q, done_d;
  logic           rdsel_q, rdsel_d;
  logic           we0_q, we0_d, we1_q, we1_d;
  logic [N_2-1:0] adr0a_q, adr0a_d, adr0b_q, adr0b_d;
  logic [N_2-1:0] adr1a_q, adr1a_d, adr1b_q, adr1b_d;
  logic [N_2-2:0] tw_q, tw_d;

  logic           go;
  logic           act;
  logic           rd_phase;
  logic           wr;
  logic [N_2-2:0] jj;
  logic [N_2-2:0] mask;

  function automatic logic [N_2-1:0] rotl(input logic [N_2-1:0] x, input logic [LW-1:0] sh);
    logic [2*N_2-1:0] d;
    d = {x, x} << sh;
    return d[2*N_2-1:N_2];
  endfunction

  assign go = bus.start && WidthOk;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (go) state_d = RUN;
      RUN: begin
        if (tail_q) begin
`ifdef FFT_AGU_DONE_PULSE_EN
          state_d = IDLE;
`else
          state_d = DONE;
`endif
        end
      end
      DONE: if (go) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Position HALF within a level is the drain slot; tail marks the cycle after the last drain.
  always_comb begin
    lvl_d  = lvl_q;
    pos_d  = pos_q;
    tail_d = tail_q;
    if (state_q != RUN) begin
      if (go) begin
        lvl_d  = '0;
        pos_d  = '0;
        tail_d = 1'b0;
      end
    end else if (!tail_q) begin
      if (pos_q == N_2'(HALF)) begin
        pos_d = '0;
        if (lvl_q == LW'(N_2 - 1)) tail_d = 1'b1;
        else                       lvl_d  = lvl_q + 1'b1;
      end else begin
        pos_d = pos_q + 1'b1;
      end
    end
  end

  // Outputs are registered: counter state in cycle k becomes the bus values of cycle k+1.
  always_comb begin
    act      = (state_q == RUN) && !tail_q;
    rd_phase = act && (pos_q != N_2'(HALF));
    wr       = act && (pos_q != '0);
    jj       = pos_q[N_2-2:0];

    mask = '0;
    for (int unsigned i = 0; i < unsigned'(N_2 - 1); i++) begin
      mask[i] = (i + 32'(lvl_q)) >= unsigned'(N_2 - 1);
    end

    rda_d   = rd_phase ? rotl({jj, 1'b0}, lvl_q) : '0;
    rdb_d   = rd_phase ? rotl({jj, 1'b1}, lvl_q) : '0;
    tw_d    = rd_phase ? (jj & mask) : '0;
    rdsel_d = act ? lvl_q[0] : rdsel_q;

    we0_d   = 1'b0;
    we1_d   = 1'b0;
    adr0a_d = '0;
    adr0b_d = '0;
    adr1a_d = '0;
    adr1b_d = '0;
    if (act) begin
      if (!lvl_q[0]) begin
        adr0a_d = rda_d;
        adr0b_d = rdb_d;
        adr1a_d = rda_q;
        adr1b_d = rdb_q;
        we1_d   = wr;
      end else begin
        adr1a_d = rda_d;
        adr1b_d = rdb_d;
        adr0a_d = rda_q;
        adr0b_d = rdb_q;
        we0_d   = wr;
      end
    end

`ifdef FFT_AGU_DONE_PULSE_EN
    done_d = (state_q == RUN) && tail_q;
`else
    done_d = ((state_q == RUN) && tail_q) || ((state_q == DONE) && !go);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lvl_q   <= '0;
      pos_q   <= '0;
      tail_q  <= 1'b0;
      rda_q   <= '0;
      rdb_q   <= '0;
      done_q  <= 1'b0;
      rdsel_q <= 1'b0;
      we0_q   <= 1'b0;
      we1_q   <= 1'b0;
      adr0a_q <= '0;
      adr0b_q <= '0;
      adr1a_q <= '0;
      adr1b_q <= '0;
      tw_q    <= '0;
    end else begin
      lvl_q   <= lvl_d;
      pos_q   <= pos_d;
      tail_q  <= tail_d;
      rda_q   <= rda_d;
      rdb_q   <= rdb_d;
      done_q  <= done_d;
      rdsel_q <= rdsel_d;
      we0_q   <= we0_d;
      we1_q   <= we1_d;
      adr0a_q <= adr0a_d;
      adr0b_q <= adr0b_d;
      adr1a_q <= adr1a_d;
      adr1b_q <= adr1b_d;
      tw_q    <= tw_d;
    end
  end

  assign bus.done       = done_q;
  assign bus.rdsel      = rdsel_q;
  assign bus.we0        = we0_q;
  assign bus.we1        = we1_q;
  assign bus.adr0a      = adr0a_q;
  assign bus.adr0b      = adr0b_q;
  assign bus.adr1a      = adr1a_q;
  assign bus.adr1b      = adr1b_q;
  assign bus.twiddleadr = tw_q;

endmodule

// File: tb/tb_fft_agu_core.sv
// Directed bench for fft_agu_core at N_2=5 (32 points, 17 cycles per level).
module tb_fft_agu_core;

`ifdef FFT_AGU_DONE_PULSE_EN
  localparam bit PULSE = 1'b1;
`else
  localparam bit PULSE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  fft_agu_core_if #(.N_2(5)) bus ();

  fft_agu_core #(.width(16), .N_2(5)) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_run();
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    cyc = 0;
  endtask

  task automatic adv(input int k);
    repeat (k - cyc) @(posedge clk);
    #1;
    cyc = k;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".done"},  32'(bus.done), 0);
    chk({tag, ".rdsel"}, 32'(bus.rdsel), 0);
    chk({tag, ".we0"},   32'(bus.we0), 0);
    chk({tag, ".we1"},   32'(bus.we1), 0);
    chk({tag, ".adr0a"}, 32'(bus.adr0a), 0);
    chk({tag, ".adr0b"}, 32'(bus.adr0b), 0);
    chk({tag, ".adr1a"}, 32'(bus.adr1a), 0);
    chk({tag, ".adr1b"}, 32'(bus.adr1b), 0);
    chk({tag, ".tw"},    32'(bus.twiddleadr), 0);
  endtask

  initial begin
    bus.start = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("rst_hold");

    @(negedge clk);
    rst_n = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("idle");

    // run 1: full transform
    start_run();
    adv(1);
    chk("c1.adr0a", 32'(bus.adr0a), 0);
    chk("c1.adr0b", 32'(bus.adr0b), 1);
    chk("c1.tw",    32'(bus.twiddleadr), 0);
    chk("c1.we0",   32'(bus.we0), 0);
    chk("c1.we1",   32'(bus.we1), 0);
    chk("c1.rdsel", 32'(bus.rdsel), 0);
    adv(2);
    chk("c2.we1",   32'(bus.we1), 1);
    chk("c2.adr1a", 32'(bus.adr1a), 0);
    chk("c2.adr1b", 32'(bus.adr1b), 1);
    chk("c2.adr0a", 32'(bus.adr0a), 2);
    chk("c2.adr0b", 32'(bus.adr0b), 3);
    adv(17);
    chk("c17.we0",   32'(bus.we0), 0);
    chk("c17.adr0a", 32'(bus.adr0a), 0);
    chk("c17.adr0b", 32'(bus.adr0b), 0);
    chk("c17.we1",   32'(bus.we1), 1);
    chk("c17.adr1a", 32'(bus.adr1a), 30);
    chk("c17.adr1b", 32'(bus.adr1b), 31);
    adv(18);
    chk("c18.rdsel", 32'(bus.rdsel), 1);
    chk("c18.adr1a", 32'(bus.adr1a), 0);
    chk("c18.adr1b", 32'(bus.adr1b), 2);
    chk("c18.we0",   32'(bus.we0), 0);
    chk("c18.we1",   32'(bus.we1), 0);
    adv(23);
    chk("l1j5.adr1a", 32'(bus.adr1a), 20);
    chk("l1j5.adr1b", 32'(bus.adr1b), 22);
    chk("l1j5.tw",    32'(bus.twiddleadr), 0);
    chk("l1j5.rdsel", 32'(bus.rdsel), 1);
    adv(24);
    chk("l1j5w.we0",   32'(bus.we0), 1);
    chk("l1j5w.adr0a", 32'(bus.adr0a), 20);
    chk("l1j5w.adr0b", 32'(bus.adr0b), 22);
    adv(41);
    chk("l2j6.adr0a", 32'(bus.adr0a), 17);
    chk("l2j6.adr0b", 32'(bus.adr0b), 21);
    chk("l2j6.tw",    32'(bus.twiddleadr), 4);
    chk("l2j6.rdsel", 32'(bus.rdsel), 0);
    bus.start = 1'b1;
    adv(42);
    bus.start = 1'b0;
    chk("l2j7.adr0a", 32'(bus.adr0a), 25);
    chk("l2j7.adr0b", 32'(bus.adr0b), 29);
    chk("l2j7.tw",    32'(bus.twiddleadr), 4);
    chk("l2j7.we1",   32'(bus.we1), 1);
    adv(74);
    chk("l4j5.adr0a", 32'(bus.adr0a), 5);
    chk("l4j5.adr0b", 32'(bus.adr0b), 21);
    chk("l4j5.tw",    32'(bus.twiddleadr), 5);
    chk("l4j5.rdsel", 32'(bus.rdsel), 0);
    adv(85);
    chk("c85.done",  32'(bus.done), 0);
    chk("c85.we1",   32'(bus.we1), 1);
    chk("c85.adr1a", 32'(bus.adr1a), 15);
    chk("c85.adr1b", 32'(bus.adr1b), 31);
    chk("c85.adr0a", 32'(bus.adr0a), 0);
    chk("c85.we0",   32'(bus.we0), 0);
    adv(86);
    chk("c86.done",  32'(bus.done), 1);
    chk("c86.we1",   32'(bus.we1), 0);
    chk("c86.adr1a", 32'(bus.adr1a), 0);
    chk("c86.tw",    32'(bus.twiddleadr), 0);
    adv(87);
    chk("c87.done", 32'(bus.done), PULSE ? 0 : 1);
    adv(90);
    chk("c90.done", 32'(bus.done), PULSE ? 0 : 1);

    // run 2: restart from completion, then reset mid-run
    start_run();
    chk("r2c0.done", 32'(bus.done), 0);
    adv(1);
    chk("r2c1.adr0a", 32'(bus.adr0a), 0);
    chk("r2c1.adr0b", 32'(bus.adr0b), 1);
    chk("r2c1.we0",   32'(bus.we0), 0);
    adv(40);
    chk("r2c40.adr0a", 32'(bus.adr0a), 9);
    chk("r2c40.we1",   32'(bus.we1), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("postrst.we1", 32'(bus.we1), 0);

    // run 3: clean restart after reset
    start_run();
    adv(1);
    chk("r3c1.adr0a", 32'(bus.adr0a), 0);
    chk("r3c1.adr0b", 32'(bus.adr0b), 1);
    chk("r3c1.rdsel", 32'(bus.rdsel), 0);
    adv(2);
    chk("r3c2.we1",   32'(bus.we1), 1);
    chk("r3c2.adr1b", 32'(bus.adr1b), 1);
    adv(18);
    chk("r3c18.rdsel", 32'(bus.rdsel), 1);
    chk("r3c18.adr1b", 32'(bus.adr1b), 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
